// File: rtl/array5_packer.sv
// array5_packer: packs five consecutive stream words into an int_5 array and hands it off over a sync/notify port.
module array5_packer #(
    localparam int N_ELEMS = 5,
    localparam int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              a_in,
    input  logic                           a_in_sync,
    output logic                           a_in_notify,
    output logic [N_ELEMS-1:0][DATA_W-1:0] b_out,
    input  logic                           b_out_sync,
    output logic                           b_out_notify
);
    typedef enum logic {COLLECT, SEND} state_t;
    localparam logic [2:0] LAST = 3'(N_ELEMS - 1);
    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic       in_xfer, out_xfer, idx_ok;
    always_comb begin
        a_in_notify  = state == COLLECT;
        b_out_notify = state == SEND;
        in_xfer      = a_in_notify && a_in_sync;
        out_xfer     = b_out_notify && b_out_sync;
        idx_ok       = idx <= LAST;
        state_nx     = state;
        idx_nx       = idx;
        // An out-of-range index can only come from a corrupted register; recover to a clean COLLECT.
        if (!idx_ok) begin
            state_nx = COLLECT;
            idx_nx   = '0;
        end else if (in_xfer) begin
            state_nx = idx == LAST ? SEND : COLLECT;
            idx_nx   = idx == LAST ? 3'd0 : idx + 3'd1;
        end else if (out_xfer) begin
            state_nx = COLLECT;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end
    // b_out is never cleared after a send; unwritten slots keep the previous array's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            b_out <= '0;
        else if (in_xfer && idx_ok)
            b_out[idx] <= a_in;
    end
endmodule

// File: tb/tb_array5_packer.sv
// tb_array5_packer: table vectors, hand-written corner sequences and randomized traffic against a queue-level model.
module tb_array5_packer;
    logic               clk = 0, rst = 0, a_in_sync = 0, b_out_sync = 0;
    logic [31:0]        a_in = 0;
    logic               a_in_notify, b_out_notify;
    logic [4:0][31:0]   b_out;
    int                 errs = 0, checks = 0;
    logic [4:0][31:0]   m_arr;
    int                 m_cnt;
    bit                 m_send;

    typedef struct {
        logic             s;
        logic [31:0]      a;
        logic             bs;
        logic             an;
        logic             bn;
        logic [4:0][31:0] b;
    } vec_t;
    vec_t tbl[13];

    array5_packer dut (
        .clk(clk), .rst(rst), .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(a_in_notify),
        .b_out(b_out), .b_out_sync(b_out_sync), .b_out_notify(b_out_notify)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0][31:0] pack5(int e0, int e1, int e2, int e3, int e4);
        logic [4:0][31:0] p;
        p[0] = e0; p[1] = e1; p[2] = e2; p[3] = e3; p[4] = e4;
        return p;
    endfunction

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_arr  = '0;
        m_cnt  = 0;
        m_send = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " a_in_notify"}, 160'(a_in_notify), 160'(!m_send));
        chk({tag, " b_out_notify"}, 160'(b_out_notify), 160'(m_send));
        chk({tag, " b_out"}, b_out, m_arr);
    endtask

    task automatic step(input logic s, input logic [31:0] a, input logic bs, input string tag);
        a_in_sync  = s;
        a_in       = a;
        b_out_sync = bs;
        @(posedge clk);
        if (!m_send && s) begin
            m_arr[m_cnt] = a;
            m_cnt++;
            if (m_cnt == 5) begin
                m_cnt  = 0;
                m_send = 1;
            end
        end else if (m_send && bs) begin
            m_send = 0;
        end
        #1 check_model(tag);
    endtask

    initial begin
        tbl[0] = '{1, 10, 0, 1, 0, pack5(10, 0, 0, 0, 0)};
        tbl[1] = '{1, 20, 0, 1, 0, pack5(10, 20, 0, 0, 0)};
        tbl[2] = '{1, 30, 0, 1, 0, pack5(10, 20, 30, 0, 0)};
        tbl[3] = '{1, 40, 0, 1, 0, pack5(10, 20, 30, 40, 0)};
        tbl[4] = '{1, 50, 0, 0, 1, pack5(10, 20, 30, 40, 50)};
        for (int i = 5; i < 12; i++)
            tbl[i] = '{1, 99, 0, 0, 1, pack5(10, 20, 30, 40, 50)};
        tbl[12] = '{1, 99, 1, 1, 0, pack5(10, 20, 30, 40, 50)};

        #2 rst = 1;
        #1;
        chk("reset a_in_notify", 160'(a_in_notify), 160'(1));
        chk("reset b_out_notify", 160'(b_out_notify), 160'(0));
        chk("reset b_out", b_out, '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].bs, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl a_in_notify", i), 160'(a_in_notify), 160'(tbl[i].an));
            chk($sformatf("vec%0d tbl b_out_notify", i), 160'(b_out_notify), 160'(tbl[i].bn));
            chk($sformatf("vec%0d tbl b_out", i), b_out, tbl[i].b);
        end

        for (int v = 1; v <= 5; v++) begin
            step(1, v, 0, "gap pulse");
            step(0, $urandom, 0, "gap idle");
            step(0, $urandom, 0, "gap idle");
        end
        chk("gap b_out", b_out, pack5(1, 2, 3, 4, 5));
        chk("gap b_out_notify", 160'(b_out_notify), 160'(1));
        step(0, 0, 1, "gap send");

        step(1, 7, 0, "stale");
        step(1, 8, 0, "stale");
        chk("stale b_out", b_out, pack5(7, 8, 3, 4, 5));
        chk("stale b_out_notify", 160'(b_out_notify), 160'(0));
        step(1, 9, 0, "refill");
        step(1, 10, 0, "refill");
        step(1, 11, 0, "refill");
        chk("refill b_out", b_out, pack5(7, 8, 9, 10, 11));
        chk("refill b_out_notify", 160'(b_out_notify), 160'(1));
        step(0, 0, 1, "refill send");

        step(1, 21, 0, "pre-rst");
        step(1, 22, 0, "pre-rst");
        step(1, 23, 0, "pre-rst");
        #2 rst = 1;
        #1;
        chk("midrst b_out", b_out, '0);
        chk("midrst a_in_notify", 160'(a_in_notify), 160'(1));
        chk("midrst b_out_notify", 160'(b_out_notify), 160'(0));
        model_reset();
        #1 rst = 0;
        for (int v = 0; v < 5; v++)
            step(1, 100 + v, 0, "post-rst");
        chk("post-rst b_out", b_out, pack5(100, 101, 102, 103, 104));
        chk("post-rst b_out_notify", 160'(b_out_notify), 160'(1));

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, "rand");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
